// File: rtl/synth_pkg.sv
// Shared types and constants for the MIDI-to-APB bridge.
// Holds FSM encodings, MIDI status codes and PWDATA field layout.
package synth_pkg;

    typedef enum logic [1:0] {
        P_IDLE,
        P_NOTE,
        P_VEL
    } parser_state_t;

    typedef enum logic [1:0] {
        A_IDLE,
        A_SETUP,
        A_ACCESS
    } apb_state_t;

    localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
    localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
    localparam logic [7:0] MIDI_RT_MIN   = 8'hF8;

    localparam int PW_VEL_LSB  = 0;
    localparam int PW_NOTE_LSB = 8;
    localparam int PW_STAT_LSB = 16;

    // Pack a note message; Note On with zero velocity becomes Note Off.
    function automatic logic [23:0] make_msg(
        input logic [7:0] status,
        input logic [7:0] note,
        input logic [7:0] vel
    );
        logic [23:0] m;
        logic [7:0]  st;
        st = status;
        if (status[7:4] == MIDI_NOTE_ON && vel == 8'h00)
            st = {MIDI_NOTE_OFF, status[3:0]};
        m = '0;
        m[PW_STAT_LSB +: 8] = st;
        m[PW_NOTE_LSB +: 8] = note;
        m[PW_VEL_LSB +: 8]  = vel;
        return m;
    endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser for Note On/Off with running status.
// Emits a one-cycle msg_valid alongside the packed 24-bit message.
module midi_msg_parser
    import synth_pkg::*;
#(
    parameter bit         CHAN_FILTER_EN = 1'b0,
    parameter logic [3:0] CHANNEL        = 4'h0
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [7:0]  midi_byte,
    input  logic        midi_valid,
    output logic        msg_valid,
    output logic [23:0] msg
);

    parser_state_t state;
    logic [7:0]    run_status;
    logic [7:0]    note;

    logic is_rt;
    logic is_data;
    logic is_note_st;
    logic is_other_st;
    logic chan_ok;

    // Classify the incoming byte and decide whether a message completes
    always_comb begin
        is_rt       = (midi_byte >= MIDI_RT_MIN);
        is_data     = ~midi_byte[7];
        is_note_st  = midi_byte[7:4] == MIDI_NOTE_OFF
                   || midi_byte[7:4] == MIDI_NOTE_ON;
        is_other_st = ~is_data & ~is_note_st;
        chan_ok     = !CHAN_FILTER_EN
                   || run_status[3:0] == CHANNEL;
        msg_valid   = midi_valid && is_data
                   && state == P_VEL && chan_ok;
        msg         = make_msg(run_status, note, midi_byte);
    end

    // Parser state, running status and note latch
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= P_IDLE;
            run_status <= 8'h00;
            note       <= 8'h00;
        end else if (midi_valid && !is_rt) begin
            unique case (1'b1)
                is_note_st: begin
                    run_status <= midi_byte;
                    state      <= P_NOTE;
                end
                is_other_st: begin
                    run_status <= 8'h00;
                    state      <= P_IDLE;
                end
                is_data: begin
                    unique case (state)
                        P_NOTE: begin
                            note  <= midi_byte;
                            state <= P_VEL;
                        end
                        P_VEL:   state <= P_NOTE;
                        default: state <= P_IDLE;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: rtl/midi_apb_master.sv
// MIDI note messages to APB writes toward the synthesizer slave.
// One-entry pending buffer, sticky overflow, no wait states.
module midi_apb_master
    import synth_pkg::*;
#(
    parameter bit         CHAN_FILTER_EN = 1'b0,
    parameter logic [3:0] CHANNEL        = 4'h0
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [7:0]  midi_byte,
    input  logic        midi_valid,
    input  logic        ovf_clear,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic        busy,
    output logic        overflow
);

    logic        msg_valid;
    logic [23:0] msg;
    logic        pend_valid;
    logic [23:0] pend_msg;
    apb_state_t  apb_state;
    logic        drain;
    logic        ovf_set;

    midi_msg_parser #(
        .CHAN_FILTER_EN (CHAN_FILTER_EN),
        .CHANNEL        (CHANNEL)
    ) u_parser (
        .clk        (clk),
        .n_rst      (n_rst),
        .midi_byte  (midi_byte),
        .midi_valid (midi_valid),
        .msg_valid  (msg_valid),
        .msg        (msg)
    );

    // Pending entry leaves whenever the APB side can start a new setup
    always_comb begin
        drain   = pend_valid
               && (apb_state == A_IDLE || apb_state == A_ACCESS);
        ovf_set = msg_valid && pend_valid && !drain;
        busy    = pend_valid || apb_state != A_IDLE;
    end

    // One-entry pending buffer; a drain frees room on the same edge
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pend_valid <= 1'b0;
            pend_msg   <= 24'h0;
        end else if (msg_valid && (!pend_valid || drain)) begin
            pend_valid <= 1'b1;
            pend_msg   <= msg;
        end else if (drain) begin
            pend_valid <= 1'b0;
        end
    end

    // Sticky overflow; a new drop outranks a clear on the same edge
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            overflow <= 1'b0;
        else if (ovf_set)
            overflow <= 1'b1;
        else if (ovf_clear)
            overflow <= 1'b0;
    end

    // APB master FSM with registered bus outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            apb_state <= A_IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PWDATA    <= 32'h0;
        end else begin
            unique case (apb_state)
                A_IDLE: begin
                    if (pend_valid) begin
                        apb_state <= A_SETUP;
                        PSEL      <= 1'b1;
                        PENABLE   <= 1'b0;
                        PWRITE    <= 1'b1;
                        PWDATA    <= {8'h00, pend_msg};
                    end
                end
                A_SETUP: begin
                    apb_state <= A_ACCESS;
                    PENABLE   <= 1'b1;
                end
                A_ACCESS: begin
                    if (pend_valid) begin
                        apb_state <= A_SETUP;
                        PENABLE   <= 1'b0;
                        PWDATA    <= {8'h00, pend_msg};
                    end else begin
                        apb_state <= A_IDLE;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        PWRITE    <= 1'b0;
                    end
                end
                default: begin
                    apb_state <= A_IDLE;
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    PWRITE    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_midi_apb_master.sv
// Self-checking bench for midi_apb_master.
// Table vectors, corner sequences and a random stream against a model.
module tb_midi_apb_master;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [7:0]  midi_byte = 8'h00;
    logic        midi_valid = 1'b0;
    logic        ovf_clear = 1'b0;

    logic        PSEL, PENABLE, PWRITE, busy, overflow;
    logic [31:0] PWDATA;
    logic        PSELf, PENABLEf, PWRITEf, busyf, overflowf;
    logic [31:0] PWDATAf;

    int checks = 0;
    int errors = 0;

    logic [31:0] got[$];
    logic [31:0] gotf[$];
    logic [31:0] exp_q[$];
    logic [31:0] expf_q[$];

    midi_apb_master dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .midi_byte  (midi_byte),
        .midi_valid (midi_valid),
        .ovf_clear  (ovf_clear),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .busy       (busy),
        .overflow   (overflow)
    );

    midi_apb_master #(
        .CHAN_FILTER_EN (1'b1),
        .CHANNEL        (4'h2)
    ) dutf (
        .clk        (clk),
        .n_rst      (n_rst),
        .midi_byte  (midi_byte),
        .midi_valid (midi_valid),
        .ovf_clear  (ovf_clear),
        .PSEL       (PSELf),
        .PENABLE    (PENABLEf),
        .PWRITE     (PWRITEf),
        .PWDATA     (PWDATAf),
        .busy       (busyf),
        .overflow   (overflowf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Record every completed APB write (ACCESS phase)
    always @(negedge clk) begin
        if (PSEL && PENABLE) begin
            got.push_back(PWDATA);
            chk("pwrite", {31'h0, PWRITE}, 32'h1);
        end
        if (PSELf && PENABLEf)
            gotf.push_back(PWDATAf);
    end

    task automatic send(input logic [7:0] b);
        midi_byte  = b;
        midi_valid = 1'b1;
        @(posedge clk);
        #1;
        midi_valid = 1'b0;
        midi_byte  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model state (spec-level, not RTL encoding)
    bit         m_have_st;
    bit         m_have_note;
    logic [7:0] m_st;
    logic [7:0] m_note;

    task automatic model_byte(input logic [7:0] b);
        logic [7:0]  st;
        logic [31:0] w;
        if (b >= 8'hF8) return;
        if (b[7]) begin
            m_have_st   = (b[7:4] == 4'h8 || b[7:4] == 4'h9);
            m_st        = b;
            m_have_note = 1'b0;
        end else if (m_have_st) begin
            if (!m_have_note) begin
                m_note      = b;
                m_have_note = 1'b1;
            end else begin
                st = m_st;
                if (st[7:4] == 4'h9 && b == 8'h00)
                    st = {4'h8, m_st[3:0]};
                w = {8'h00, st, m_note, b};
                exp_q.push_back(w);
                if (m_st[3:0] == 4'h2)
                    expf_q.push_back(w);
                m_have_note = 1'b0;
            end
        end
    endtask

    typedef struct {
        logic [7:0]  b[8];
        int          nb;
        logic [31:0] w[2];
        int          nw;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0].b  = '{8'h91, 8'h3C, 8'h64, 0, 0, 0, 0, 0};
        tbl[0].nb = 3;
        tbl[0].w  = '{32'h00913C64, 0};
        tbl[0].nw = 1;
        tbl[1].b  = '{8'h90, 8'h40, 8'h50, 8'h43, 8'h00, 0, 0, 0};
        tbl[1].nb = 5;
        tbl[1].w  = '{32'h00904050, 32'h00804300};
        tbl[1].nw = 2;
        tbl[2].b  = '{8'h90, 8'h40, 8'hF8, 8'h7F, 0, 0, 0, 0};
        tbl[2].nb = 4;
        tbl[2].w  = '{32'h0090407F, 0};
        tbl[2].nw = 1;
        tbl[3].b  = '{8'h90, 8'h40, 8'hB0, 8'h40, 8'h7F, 0, 0, 0};
        tbl[3].nb = 5;
        tbl[3].w  = '{0, 0};
        tbl[3].nw = 0;
        tbl[4].b  = '{8'h80, 8'h10, 8'h20, 0, 0, 0, 0, 0};
        tbl[4].nb = 3;
        tbl[4].w  = '{32'h00801020, 0};
        tbl[4].nw = 1;
        tbl[5].b  = '{8'h92, 8'h11, 8'hF0, 8'h22, 8'h33, 0, 0, 0};
        tbl[5].nb = 5;
        tbl[5].w  = '{0, 0};
        tbl[5].nw = 0;

        // Reset values
        #12;
        chk("rst_psel", {31'h0, PSEL}, 32'h0);
        chk("rst_penable", {31'h0, PENABLE}, 32'h0);
        chk("rst_pwrite", {31'h0, PWRITE}, 32'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_ovf", {31'h0, overflow}, 32'h0);
        @(negedge clk);
        n_rst = 1'b1;
        idle(2);

        // Latency of a single message
        send(8'h91);
        send(8'h3C);
        send(8'h64);
        chk("e0_busy", {31'h0, busy}, 32'h1);
        chk("e0_psel", {31'h0, PSEL}, 32'h0);
        idle(1);
        chk("e1_psel", {31'h0, PSEL}, 32'h1);
        chk("e1_penable", {31'h0, PENABLE}, 32'h0);
        chk("e1_pwdata", PWDATA, 32'h00913C64);
        idle(1);
        chk("e2_psel", {31'h0, PSEL}, 32'h1);
        chk("e2_penable", {31'h0, PENABLE}, 32'h1);
        idle(1);
        chk("e3_psel", {31'h0, PSEL}, 32'h0);
        chk("e3_busy", {31'h0, busy}, 32'h0);
        chk("e3_pwdata_hold", PWDATA, 32'h00913C64);
        idle(2);
        got.delete();

        // Table vectors
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < tbl[v].nb; i++)
                send(tbl[v].b[i]);
            idle(8);
            chk($sformatf("vec%0d_count", v), got.size(), tbl[v].nw);
            for (int i = 0; i < tbl[v].nw; i++)
                if (i < got.size())
                    chk($sformatf("vec%0d_w%0d", v, i), got[i],
                        tbl[v].w[i]);
            got.delete();
        end

        // Channel filter
        gotf.delete();
        send(8'h92); send(8'h30); send(8'h10);
        idle(6);
        send(8'h93); send(8'h30); send(8'h10);
        idle(6);
        chk("filt_count", gotf.size(), 1);
        if (gotf.size() > 0)
            chk("filt_w0", gotf[0], 32'h00923010);
        chk("filt_ovf", {31'h0, overflowf}, 32'h0);
        chk("nofilt_count", got.size(), 2);
        got.delete();
        gotf.delete();

        // Forced completions on three consecutive edges
        force dut.msg_valid = 1'b1;
        force dut.msg = 24'h901111;
        idle(1);
        force dut.msg = 24'h902222;
        idle(1);
        force dut.msg = 24'h903333;
        ovf_clear = 1'b1;
        idle(1);
        release dut.msg_valid;
        release dut.msg;
        ovf_clear = 1'b0;
        chk("ovf_set_wins", {31'h0, overflow}, 32'h1);
        chk("f_e2_penable", {31'h0, PENABLE}, 32'h1);
        chk("f_e2_pwdata", PWDATA, 32'h00901111);
        idle(1);
        chk("f_e3_psel", {31'h0, PSEL}, 32'h1);
        chk("f_e3_penable", {31'h0, PENABLE}, 32'h0);
        chk("f_e3_pwdata", PWDATA, 32'h00902222);
        idle(4);
        chk("f_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("f_w0", got[0], 32'h00901111);
            chk("f_w1", got[1], 32'h00902222);
        end
        chk("ovf_sticky", {31'h0, overflow}, 32'h1);
        ovf_clear = 1'b1;
        idle(1);
        ovf_clear = 1'b0;
        chk("ovf_cleared", {31'h0, overflow}, 32'h0);
        got.delete();

        // Random stream against the reference model
        #2;
        n_rst = 1'b0;
        #3;
        n_rst = 1'b1;
        idle(1);
        m_have_st   = 1'b0;
        m_have_note = 1'b0;
        m_st        = 8'h00;
        m_note      = 8'h00;
        exp_q.delete();
        expf_q.delete();
        got.delete();
        gotf.delete();
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 99);
            if (r < 25)
                b = {($urandom_range(0, 1) == 0) ? 4'h8 : 4'h9,
                     2'b00, 2'($urandom_range(0, 3))};
            else if (r < 30)
                b = 8'($urandom_range(8'hA0, 8'hF7));
            else if (r < 38)
                b = 8'($urandom_range(8'hF8, 8'hFF));
            else if (r < 45)
                b = 8'h00;
            else
                b = 8'($urandom_range(0, 127));
            model_byte(b);
            send(b);
            if ($urandom_range(0, 9) < 3)
                idle($urandom_range(1, 3));
        end
        idle(10);
        chk("rnd_count", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got.size())
                chk($sformatf("rnd_w%0d", i), got[i], exp_q[i]);
        chk("rndf_count", gotf.size(), expf_q.size());
        for (int i = 0; i < expf_q.size(); i++)
            if (i < gotf.size())
                chk($sformatf("rndf_w%0d", i), gotf[i], expf_q[i]);
        chk("rnd_ovf", {31'h0, overflow}, 32'h0);
        got.delete();

        // Reset asserted during ACCESS
        send(8'h91); send(8'h3C); send(8'h64);
        idle(2);
        chk("pre_rst_penable", {31'h0, PENABLE}, 32'h1);
        #2;
        n_rst = 1'b0;
        #1;
        chk("async_psel", {31'h0, PSEL}, 32'h0);
        chk("async_penable", {31'h0, PENABLE}, 32'h0);
        chk("async_pwdata", PWDATA, 32'h0);
        chk("async_busy", {31'h0, busy}, 32'h0);
        #4;
        n_rst = 1'b1;
        idle(1);
        send(8'h40);
        send(8'h50);
        idle(6);
        chk("post_rst_count", got.size(), 0);
        send(8'h91); send(8'h3C); send(8'h64);
        idle(6);
        chk("post_rst_new", got.size(), 1);
        if (got.size() > 0)
            chk("post_rst_w", got[0], 32'h00913C64);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
